// File: rtl/sign_restore_serial.sv
// Bit-serial sign-magnitude to two's-complement converter.
// Rebuilds the signed word LSB first using the invert-and-ripple-carry rule.
module sign_restore_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] mag,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] P,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-2:0] acc_q, acc_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             ovfp_q, ovfp_d;
   logic             m;
   logic             bit_out;
   logic             last;

   assign m       = opnd_q[0];
   assign bit_out = sign_q ? (~m ^ carry_q) : m;
   assign last    = (cnt_q == CW'(WIDTH - 1));

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign P    = p_q;
   assign ovf  = ovf_q;

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      ovfp_d  = ovfp_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = SHIFT;
               opnd_d  = mag;
               sign_d  = sign;
               carry_d = 1'b1;
               cnt_d   = '0;
               // Only the most-negative value fits with the MSB set.
               ovfp_d  = mag[WIDTH-1] &
                         ~(sign & ~|mag[WIDTH-2:0]);
            end
         end
         SHIFT: begin
            opnd_d  = {1'b0, opnd_q[WIDTH-1:1]};
            acc_d   = (WIDTH-1)'({bit_out, acc_q} >> 1);
            carry_d = sign_q ? (~m & carry_q) : carry_q;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               p_d     = {bit_out, acc_q};
               ovf_d   = ovfp_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opnd_q  <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         carry_q <= 1'b1;
         ovf_q   <= 1'b0;
         ovfp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         ovfp_q  <= ovfp_d;
      end
   end

endmodule

// File: tb/tb_sign_restore_serial.sv
// Self-checking bench for sign_restore_serial.
// Directed boundary cases plus random words against an arithmetic model.
module tb_sign_restore_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic [W-1:0] mag = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] P;
   logic         ovf;

   int n_chk = 0;
   int n_fail = 0;

   sign_restore_serial #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .sign (sign),
      .mag  (mag),
      .busy (busy),
      .done (done),
      .P    (P),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_p(input logic [W-1:0] m,
                                            input logic s);
      int v;
      v = s ? -int'(m) : int'(m);
      return W'(v);
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] m,
                                      input logic s);
      int lim;
      lim = s ? (1 << (W - 1)) : ((1 << (W - 1)) - 1);
      return int'(m) > lim;
   endfunction

   task automatic launch(input logic [W-1:0] m, input logic s);
      mag = m;
      sign = s;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input bit disturb, input string tag);
      int n;
      bit both;
      n = 0;
      both = 0;
      while (!done && n < 40) begin
         if (disturb && (n == 3 || n == 10)) begin
            start = 1'b1;
            mag = W'($urandom);
            sign = 1'($urandom);
         end
         step();
         start = 1'b0;
         n++;
         if (busy && done) both = 1;
      end
      chk({tag, "_lat"}, n, W);
      chk({tag, "_busydone"}, {31'd0, both}, 32'd0);
   endtask

   task automatic check_res(input logic [W-1:0] m, input logic s,
                            input string tag);
      chk({tag, "_P"}, {16'd0, P}, {16'd0, model_p(m, s)});
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, model_ovf(m, s)});
   endtask

   task automatic op(input logic [W-1:0] m, input logic s,
                     input string tag);
      launch(m, s);
      wait_done(0, tag);
      check_res(m, s, tag);
      step();
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] rm;
      logic         rs;
      bit           act;

      step();
      rst = 1'b0;
      step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_P", {16'd0, P}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);

      rst = 1'b1;
      start = 1'b1;
      mag = 16'h1234;
      sign = 1'b1;
      act = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (busy || done) act = 1;
      end
      chk("rst_hold_act", {31'd0, act}, 32'd0);
      chk("rst_hold_P", {16'd0, P}, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      step();

      op(16'h0005, 1'b1, "neg5");
      op(16'h7FFF, 1'b0, "pos7fff");
      op(16'h8000, 1'b1, "mostneg");
      op(16'h8000, 1'b0, "ovf8000");
      op(16'h9000, 1'b1, "ovf9000");
      op(16'h0000, 1'b1, "negzero");

      launch(16'h0003, 1'b1);
      wait_done(1, "ignore");
      check_res(16'h0003, 1'b1, "ignore");
      act = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy || done) act = 1;
      end
      chk("ignore_second", {31'd0, act}, 32'd0);
      chk("ignore_Phold", {16'd0, P}, 32'hFFFD);

      launch(16'h0042, 1'b0);
      wait_done(0, "b2b_a");
      check_res(16'h0042, 1'b0, "b2b_a");
      launch(16'h1234, 1'b1);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_done", {31'd0, done}, 32'd0);
      wait_done(0, "b2b_b");
      check_res(16'h1234, 1'b1, "b2b_b");
      chk("b2b_P", {16'd0, P}, 32'hEDCC);
      step();

      launch(16'h0077, 1'b1);
      for (int i = 0; i < 7; i++) step();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_P", {16'd0, P}, 32'd0);
      act = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) act = 1;
         step();
      end
      chk("abort_nodone", {31'd0, act}, 32'd0);
      op(16'h0001, 1'b1, "fresh1");

      for (int i = 0; i < 24; i++) begin
         rm = W'($urandom);
         rs = 1'($urandom);
         if (i % 6 == 0) rm[W-1] = 1'b1;
         op(rm, rs, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
